// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM state encoding and register-zero constant.
// Pure declarations; no latency or flow control of its own.
package pipeline_ctrl_pkg;

  localparam int STATE_W  = 2;
  localparam int REG_ZERO = 0;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Cycle counter for data-memory waits; tc flags the last tolerated cycle (MEM_TIMEOUT-1).
// State updates one cycle after start/en/clr; no flow control.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  localparam int W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic start,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt_q;

  // start loads 1 because the cycle that raised the stall is already the first wait cycle
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= W'(1);
    end else if (en) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tc = (cnt_q == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; Mealy controls (zero latency), memory-wait watchdog.
// Optional saturating stall/flush counters when CTRL_PERF_EN is defined.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] ifid_rs_i,
  input  logic [REG_AW-1:0] ifid_rt_i,
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rt_i,
  input  logic              branch_taken_i,
  input  logic              dmem_req_i,
  input  logic              dmem_ack_i,
  output logic              pc_hold_o,
  output logic              ifid_hold_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              exmem_hold_o,
  output logic              memwb_bubble_o,
  output logic [STATE_W-1:0] state_o,
  output logic              err_o
`ifdef CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  ctrl_state_e state_q;
  logic        err_q;
  logic        load_use;
  logic        mem_stall;
  logic        tmr_start;
  logic        tmr_en;
  logic        tmr_clr;
  logic        tmr_tc;

  assign load_use = idex_memread_i && (idex_rt_i != REG_AW'(REG_ZERO)) &&
                    ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
  assign mem_stall = dmem_req_i && !dmem_ack_i;

  // Controls are forced quiet while reset is asserted so the stages never see a stale hold.
  always_comb begin
    pc_hold_o      = 1'b0;
    ifid_hold_o    = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    exmem_hold_o   = 1'b0;
    memwb_bubble_o = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        ST_RUN: begin
          if (mem_stall) begin
            pc_hold_o      = 1'b1;
            ifid_hold_o    = 1'b1;
            exmem_hold_o   = 1'b1;
            memwb_bubble_o = 1'b1;
          end else if (load_use) begin
            pc_hold_o     = 1'b1;
            ifid_hold_o   = 1'b1;
            idex_bubble_o = 1'b1;
          end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (!dmem_ack_i) begin
            pc_hold_o      = 1'b1;
            ifid_hold_o    = 1'b1;
            exmem_hold_o   = 1'b1;
            memwb_bubble_o = 1'b1;
          end
        end
        ST_ERROR: begin
          pc_hold_o      = 1'b1;
          ifid_hold_o    = 1'b1;
          exmem_hold_o   = 1'b1;
          memwb_bubble_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tmr_start = (state_q == ST_RUN) && mem_stall;
  assign tmr_clr   = (state_q == ST_MEM_WAIT) && dmem_ack_i;
  assign tmr_en    = (state_q == ST_MEM_WAIT) && !dmem_ack_i && !tmr_tc;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (tmr_clr),
    .start (tmr_start),
    .en    (tmr_en),
    .tc    (tmr_tc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN:      if (mem_stall) state_q <= ST_MEM_WAIT;
        ST_MEM_WAIT: begin
          if (dmem_ack_i) begin
            state_q <= ST_RUN;
          end else if (tmr_tc) begin
            state_q <= ST_ERROR;
            err_q   <= 1'b1;
          end
        end
        ST_ERROR:    state_q <= ST_ERROR;
        default:     state_q <= ST_RUN;
      endcase
    end
  end

  assign state_o = state_q;
  assign err_o   = err_q;

`ifdef CTRL_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (pc_hold_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (ifid_flush_o && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected controls queued per step, popped at mid-cycle.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       idex_memread, branch_taken, dmem_req, dmem_ack;
  logic       pc_hold, ifid_hold, ifid_flush, idex_bubble, exmem_hold, memwb_bubble;
  logic [1:0] state;
  logic       err;
`ifdef CTRL_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  // {pc_hold, ifid_hold, ifid_flush, idex_bubble, exmem_hold, memwb_bubble}
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b110100;
  localparam logic [5:0] C_FL   = 6'b001000;
  localparam logic [5:0] C_MEM  = 6'b110011;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ifid_rs_i      (ifid_rs),
    .ifid_rt_i      (ifid_rt),
    .idex_memread_i (idex_memread),
    .idex_rt_i      (idex_rt),
    .branch_taken_i (branch_taken),
    .dmem_req_i     (dmem_req),
    .dmem_ack_i     (dmem_ack),
    .pc_hold_o      (pc_hold),
    .ifid_hold_o    (ifid_hold),
    .ifid_flush_o   (ifid_flush),
    .idex_bubble_o  (idex_bubble),
    .exmem_hold_o   (exmem_hold),
    .memwb_bubble_o (memwb_bubble),
    .state_o        (state),
    .err_o          (err)
`ifdef CTRL_PERF_EN
    ,
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
`endif
  );

  task automatic step(input string tag, input logic r, input logic mr, input logic [4:0] irt,
                      input logic [4:0] rs, input logic [4:0] rt, input logic br,
                      input logic rq, input logic ak,
                      input logic [5:0] ctl, input logic [1:0] st, input logic er);
    logic [8:0] exp_v, obs_v;
    @(negedge clk);
    rst = r; idex_memread = mr; idex_rt = irt; ifid_rs = rs; ifid_rt = rt;
    branch_taken = br; dmem_req = rq; dmem_ack = ak;
    exp_q.push_back({ctl, st, er});
    #1;
    exp_v = exp_q.pop_front();
    obs_v = {pc_hold, ifid_hold, ifid_flush, idex_bubble, exmem_hold, memwb_bubble, state, err};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs_v, exp_v);
    end
  endtask

  initial begin
    rst = 1'b1; idex_memread = 1'b0; idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
    branch_taken = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(posedge clk);

    // reset quiets controls even with a hazard present
    step("rst_hazard", 1, 1, 5, 5, 0, 1, 0, 0, C_NONE, 2'd0, 0);
    step("rst_idle",   1, 0, 0, 0, 0, 0, 0, 0, C_NONE, 2'd0, 0);
    step("idle",       0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 2'd0, 0);

    step("lu_rs",      0, 1, 5, 5, 0, 0, 0, 0, C_LU,   2'd0, 0);
    step("lu_after",   0, 0, 5, 5, 0, 0, 0, 0, C_NONE, 2'd0, 0);
    step("lu_r0",      0, 1, 0, 0, 0, 0, 0, 0, C_NONE, 2'd0, 0);
    step("no_load",    0, 0, 9, 9, 9, 0, 0, 0, C_NONE, 2'd0, 0);
    step("br_only",    0, 0, 0, 0, 0, 1, 0, 0, C_FL,   2'd0, 0);
    step("br_lu",      0, 1, 3, 1, 3, 1, 0, 0, C_LU,   2'd0, 0);
    step("req_ack",    0, 0, 0, 0, 0, 0, 1, 1, C_NONE, 2'd0, 0);
    step("req_ack_nx", 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 2'd0, 0);

    step("mw_enter",   0, 0, 0, 0, 0, 0, 1, 0, C_MEM,  2'd0, 0);
    step("mw_1",       0, 0, 0, 0, 0, 0, 1, 0, C_MEM,  2'd1, 0);
    step("mw_2_ign",   0, 1, 4, 4, 0, 1, 1, 0, C_MEM,  2'd1, 0);
    step("mw_ack",     0, 0, 0, 0, 0, 0, 1, 1, C_NONE, 2'd1, 0);
    step("mw_back",    0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 2'd0, 0);
`ifdef CTRL_PERF_EN
    checks++;
    assert (stall_cnt === 16'd5) else begin
      errors++;
      $error("FAIL stall_cnt: observed %0d expected 5", stall_cnt);
    end
    checks++;
    assert (flush_cnt === 16'd1) else begin
      errors++;
      $error("FAIL flush_cnt: observed %0d expected 1", flush_cnt);
    end
`endif

    step("lu_rt",      0, 1, 7, 2, 7, 0, 0, 0, C_LU,   2'd0, 0);
    step("mem_over_lu",0, 1, 7, 2, 7, 1, 1, 0, C_MEM,  2'd0, 0);
    step("mw_rst_wait",0, 0, 0, 0, 0, 0, 1, 0, C_MEM,  2'd1, 0);
    step("mw_rst",     1, 0, 0, 0, 0, 0, 1, 0, C_NONE, 2'd1, 0);
    step("mw_rst_nx",  0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 2'd0, 0);

    // watchdog: one RUN stall cycle plus 15 MEM_WAIT cycles, then ERROR
    step("wd_enter",   0, 0, 0, 0, 0, 0, 1, 0, C_MEM,  2'd0, 0);
    for (int i = 1; i < 16; i++) begin
      step($sformatf("wd_wait%0d", i), 0, 0, 0, 0, 0, 0, 1, 0, C_MEM, 2'd1, 0);
    end
    step("wd_error",   0, 0, 0, 0, 0, 0, 1, 0, C_MEM,  2'd2, 1);
    step("wd_late_ack",0, 0, 0, 0, 0, 1, 1, 1, C_MEM,  2'd2, 1);
    step("wd_sticky",  0, 0, 0, 0, 0, 0, 0, 0, C_MEM,  2'd2, 1);
    step("wd_rst",     1, 0, 0, 0, 0, 0, 0, 0, C_NONE, 2'd2, 1);
    step("wd_cleared", 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 2'd0, 0);
    step("wd_br_ok",   0, 0, 0, 0, 0, 1, 0, 0, C_FL,   2'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
